process_scheduler: RTL

- Sits directly downstream of the quantum counter.
- Consumes its context-switch, I/O-block and end-of-process signals together with the saved PC.
- Keeps a round-robin process table of saved PCs and states, selects the next runnable process, and drives a one-cycle PC load to the PC unit.
- Publishes processoAtual back to the quantum counter. When nothing is runnable, loads the OS idle PC.

---
 rtl/process_scheduler_if.sv | 44 ++++
 rtl/process_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/process_scheduler_if.sv
// Bus between the quantum counter / PC unit side and the process scheduler.
// Optional statistics outputs exist only when SCHED_STATS_EN is defined.
interface process_scheduler_if #(
  parameter int ID_W = 3
);
  logic            troca_contexto;
  logic            intrucaoIOContexto;
  logic            fimProcesso;
  logic [31:0]     pc_processo_trocado;
  logic            proc_create;
  logic [ID_W-1:0] proc_create_id;
  logic [31:0]     proc_create_pc;
  logic            io_done;
  logic [ID_W-1:0] io_done_id;
  logic [ID_W-1:0] processoAtual;
  logic [31:0]     pc_novo;
  logic            pc_load;
  logic            sistema_ocioso;
  logic            create_err;
`ifdef SCHED_STATS_EN
  logic [31:0]     trocas_total;
  logic [31:0]     ocioso_ciclos;
`endif

  // Requester side: quantum counter, process creator, I/O unit, PC unit.
  modport master (
    output troca_contexto, intrucaoIOContexto, fimProcesso, pc_processo_trocado,
    output proc_create, proc_create_id, proc_create_pc, io_done, io_done_id,
`ifdef SCHED_STATS_EN
    input  trocas_total, ocioso_ciclos,
`endif
    input  processoAtual, pc_novo, pc_load, sistema_ocioso, create_err
  );

  // Scheduler side.
  modport slave (
    input  troca_contexto, intrucaoIOContexto, fimProcesso, pc_processo_trocado,
    input  proc_create, proc_create_id, proc_create_pc, io_done, io_done_id,
`ifdef SCHED_STATS_EN
    output trocas_total, ocioso_ciclos,
`endif
    output processoAtual, pc_novo, pc_load, sistema_ocioso, create_err
  );
endinterface

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: keeps a table of saved PCs/states, picks the
// next runnable process after a preempt/block/finish and strobes a PC load.
// Optional macro SCHED_STATS_EN adds switch and idle-cycle counters.
module process_scheduler #(
  parameter int          NPROC = 8,
  parameter int          ID_W  = 3,
  parameter logic [31:0] SO_PC = 32'd0
) (
  input logic                clock,
  input logic                reset,
  process_scheduler_if.slave bus
);

  typedef enum logic [1:0] {LIVRE, PRONTO, EXEC, BLOQ} ent_e;
  typedef enum logic [1:0] {RUN, SEARCH, LOAD} fsm_e;

  localparam logic [ID_W-1:0] LAST = ID_W'(NPROC - 1);

  ent_e            st_q [NPROC];
  logic [31:0]     pc_q [NPROC];
  fsm_e            fsm_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] cnt_q;
  logic [ID_W-1:0] sel_q;
  logic [ID_W-1:0] cur_q;
  logic [31:0]     pc_novo_q;
  logic            pc_load_q;
  logic            ocioso_q;
  logic            create_err_q;
  logic            any_pronto;
  logic            event_any;

  // Any runnable entry in the table (pre-edge view).
  always_comb begin
    any_pronto = 1'b0;
    for (int unsigned i = 0; i < NPROC; i++)
      if (st_q[i] == PRONTO) any_pronto = 1'b1;
  end

  assign event_any = bus.fimProcesso | bus.intrucaoIOContexto | bus.troca_contexto;

  // Process table, create/io_done handling and the RUN/SEARCH/LOAD sequencer.
  // Create/io_done only ever touch LIVRE/BLOQ entries while the sequencer only
  // touches the EXEC or selected PRONTO entry, so their writes never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NPROC; i++) begin
        st_q[i] <= LIVRE;
        pc_q[i] <= '0;
      end
      fsm_q        <= RUN;
      ptr_q        <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      cur_q        <= '0;
      pc_novo_q    <= '0;
      pc_load_q    <= 1'b0;
      ocioso_q     <= 1'b1;
      create_err_q <= 1'b0;
    end else begin
      pc_load_q    <= 1'b0;
      create_err_q <= 1'b0;

      if (bus.proc_create) begin
        if (st_q[bus.proc_create_id] == LIVRE) begin
          st_q[bus.proc_create_id] <= PRONTO;
          pc_q[bus.proc_create_id] <= bus.proc_create_pc;
        end else begin
          create_err_q <= 1'b1;
        end
      end

      if (bus.io_done && (st_q[bus.io_done_id] == BLOQ))
        st_q[bus.io_done_id] <= PRONTO;

      case (fsm_q)
        RUN: begin
          if (!ocioso_q) begin
            if (bus.fimProcesso) begin
              st_q[cur_q] <= LIVRE;
            end else if (bus.intrucaoIOContexto) begin
              pc_q[cur_q] <= bus.pc_processo_trocado;
              st_q[cur_q] <= BLOQ;
            end else if (bus.troca_contexto) begin
              pc_q[cur_q] <= bus.pc_processo_trocado;
              st_q[cur_q] <= PRONTO;
            end
            if (event_any) begin
              fsm_q <= SEARCH;
              ptr_q <= cur_q + 1'b1;
              cnt_q <= '0;
            end
          end else if (any_pronto) begin
            fsm_q <= SEARCH;
            ptr_q <= cur_q + 1'b1;
            cnt_q <= '0;
          end
        end
        SEARCH: begin
          if (st_q[ptr_q] == PRONTO) begin
            sel_q <= ptr_q;
            fsm_q <= LOAD;
          end else if (cnt_q == LAST) begin
            pc_novo_q <= SO_PC;
            pc_load_q <= 1'b1;
            ocioso_q  <= 1'b1;
            fsm_q     <= RUN;
          end else begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LOAD: begin
          pc_novo_q   <= pc_q[sel_q];
          pc_load_q   <= 1'b1;
          cur_q       <= sel_q;
          st_q[sel_q] <= EXEC;
          ocioso_q    <= 1'b0;
          fsm_q       <= RUN;
        end
        default: fsm_q <= RUN;
      endcase
    end
  end

  assign bus.processoAtual  = cur_q;
  assign bus.pc_novo        = pc_novo_q;
  assign bus.pc_load        = pc_load_q;
  assign bus.sistema_ocioso = ocioso_q;
  assign bus.create_err     = create_err_q;

`ifdef SCHED_STATS_EN
  logic [31:0] trocas_q;
  logic [31:0] ocioso_ciclos_q;

  // Switch counter wraps; idle-cycle counter saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      trocas_q        <= '0;
      ocioso_ciclos_q <= '0;
    end else begin
      if (fsm_q == LOAD) trocas_q <= trocas_q + 32'd1;
      if (ocioso_q && (ocioso_ciclos_q != '1)) ocioso_ciclos_q <= ocioso_ciclos_q + 32'd1;
    end
  end

  assign bus.trocas_total  = trocas_q;
  assign bus.ocioso_ciclos = ocioso_ciclos_q;
`endif

endmodule
